// File: rtl/scan_point_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_point_feeder_if
// Brief    : Point stream, IMU and corrector-side bus for scan_point_feeder.
// Revision : 1.0  initial release
// ============================================================================
interface scan_point_feeder_if #(
    parameter int WP   = 32,
    parameter int NPTS = 1024
);
    localparam int c_IW = $clog2(NPTS);

    logic            scan_start;
    logic            in_valid;
    logic            in_ready;
    logic [WP-1:0]   in_px;
    logic [WP-1:0]   in_py;
    logic [WP-1:0]   in_pz;
    logic            imu_valid;
    logic [WP-1:0]   imu_ax;
    logic            out_valid;
    logic            out_ready;
    logic [WP-1:0]   out_px;
    logic [WP-1:0]   out_py;
    logic [WP-1:0]   out_pz;
    logic [WP-1:0]   out_dt;
    logic [WP-1:0]   out_a_x;
    logic [WP-1:0]   out_v_prev;
    logic [WP-1:0]   v_next_in;
    logic            scan_busy;
    logic            scan_done;
    logic [c_IW-1:0] pt_idx;

    modport slave (
        input  scan_start, in_valid, in_px, in_py, in_pz,
        input  imu_valid, imu_ax, out_ready, v_next_in,
        output in_ready, out_valid, out_px, out_py, out_pz,
        output out_dt, out_a_x, out_v_prev, scan_busy, scan_done, pt_idx
    );

    modport master (
        output scan_start, in_valid, in_px, in_py, in_pz,
        output imu_valid, imu_ax, out_ready, v_next_in,
        input  in_ready, out_valid, out_px, out_py, out_pz,
        input  out_dt, out_a_x, out_v_prev, scan_busy, scan_done, pt_idx
    );
endinterface
`default_nettype wire

// File: rtl/scan_point_feeder.sv
`default_nettype none
// ============================================================================
// Module   : scan_point_feeder
// Brief    : Feeds one LiDAR scan into the motion corrector, stamping dt/ax and
//            closing the velocity loop. Macro SCAN_VEL_CARRY_EN keeps velocity
//            across scans instead of clearing it on scan_start.
// Revision : 1.0  initial release
// ============================================================================
module scan_point_feeder #(
    parameter int WP      = 32,
    parameter int NPTS    = 1024,
    parameter int DT_STEP = 13
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    scan_point_feeder_if.slave bus
);
    localparam int c_IW = $clog2(NPTS);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [WP-1:0]   c_DT_MAX  = {1'b0, {(WP-1){1'b1}}};
    localparam logic [WP-1:0]   c_DT_STEP = WP'(DT_STEP);
    localparam logic [c_IW-1:0] c_LAST    = c_IW'(NPTS - 1);

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_pt_idx;
    logic [WP-1:0]   r_dt_acc;
    logic [WP-1:0]   r_v_reg;
    logic [WP-1:0]   r_ax_reg;
    logic            r_out_valid;
    logic [WP-1:0]   r_out_px;
    logic [WP-1:0]   r_out_py;
    logic [WP-1:0]   r_out_pz;
    logic [WP-1:0]   r_out_dt;
    logic [WP-1:0]   r_out_a_x;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_out_hs;
    logic [WP:0]     w_dt_sum;
    logic [WP-1:0]   w_dt_next;

    // Single output stage: a new point may enter whenever the slot drains this cycle.
    assign w_in_ready = (r_state == c_RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;
    assign w_dt_sum   = {1'b0, r_dt_acc} + {1'b0, c_DT_STEP};
    assign w_dt_next  = (w_dt_sum > {1'b0, c_DT_MAX}) ? c_DT_MAX : w_dt_sum[WP-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_pt_idx    <= '0;
            r_dt_acc    <= '0;
            r_v_reg     <= '0;
            r_ax_reg    <= '0;
            r_out_valid <= 1'b0;
            r_out_px    <= '0;
            r_out_py    <= '0;
            r_out_pz    <= '0;
            r_out_dt    <= '0;
            r_out_a_x   <= '0;
        end else begin
            if (bus.imu_valid) begin
                r_ax_reg <= bus.imu_ax;
            end

            if (w_accept) begin
                r_out_px  <= bus.in_px;
                r_out_py  <= bus.in_py;
                r_out_pz  <= bus.in_pz;
                r_out_dt  <= r_dt_acc;
                r_out_a_x <= r_ax_reg;
                r_dt_acc  <= w_dt_next;
                r_pt_idx  <= r_pt_idx + c_IW'(1);
            end

            if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_hs) begin
                r_v_reg <= bus.v_next_in;
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.scan_start) begin
                        r_state  <= c_RUN;
                        r_pt_idx <= '0;
                        r_dt_acc <= '0;
`ifndef SCAN_VEL_CARRY_EN
                        r_v_reg  <= '0;
`endif
                    end
                end
                c_RUN: begin
                    if (w_accept && (r_pt_idx == c_LAST)) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_out_hs) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_px     = r_out_px;
    assign bus.out_py     = r_out_py;
    assign bus.out_pz     = r_out_pz;
    assign bus.out_dt     = r_out_dt;
    assign bus.out_a_x    = r_out_a_x;
    assign bus.out_v_prev = r_v_reg;
    assign bus.scan_busy  = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign bus.scan_done  = (r_state == c_DONE);
    assign bus.pt_idx     = r_pt_idx;
endmodule
`default_nettype wire

// File: tb/tb_scan_point_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_point_feeder
// Brief    : Randomized scoreboard bench for scan_point_feeder (NPTS=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_point_feeder;
    localparam int  WP      = 32;
    localparam int  NPTS    = 4;
    localparam int  DT_STEP = 13;
    localparam logic [31:0] VSTEP = 32'h0001_0000;

    typedef struct {
        logic [31:0] px, py, pz, dt, ax, vp;
    } pt_t;

    logic clk;
    logic rst_n;

    scan_point_feeder_if #(.WP(WP), .NPTS(NPTS)) ifc ();

    scan_point_feeder #(.WP(WP), .NPTS(NPTS), .DT_STEP(DT_STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Corrector stand-in: each point adds one unit of velocity.
    assign ifc.v_next_in = ifc.out_v_prev + VSTEP;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    pt_t         q[$];
    logic [31:0] seen_vp[$];
    logic [31:0] seen_ax[$];
    int          k_in, k_out, cyc_n, last_acc_cyc, done_cyc;
    bit          busy_m, done_due;
    logic [31:0] ax_m, v0_m, v_last_m;

    function automatic logic [31:0] exp_dt(input int k);
        longint t;
        t = longint'(k) * DT_STEP;
        return (t > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : t[31:0];
    endfunction

    task automatic model_reset();
        q.delete();
        k_in = 0; k_out = 0; busy_m = 0; done_due = 0;
        ax_m = '0; v0_m = '0; v_last_m = '0;
    endtask

    // One clock: drive inputs just after negedge, compare, advance the model.
    task automatic drive_cycle(input bit st, input bit iv, input bit ordy,
                               input bit imv, input logic [31:0] ax);
        bit exp_ov, exp_ir, idle_m, done_nxt;
        pt_t p;
        ifc.scan_start = st;
        ifc.in_valid   = iv;
        ifc.in_px      = $urandom;
        ifc.in_py      = $urandom;
        ifc.in_pz      = $urandom;
        ifc.out_ready  = ordy;
        ifc.imu_valid  = imv;
        ifc.imu_ax     = ax;
        #1;
        exp_ov = (q.size() > 0);
        exp_ir = busy_m && (k_in < NPTS) && (!exp_ov || ordy);
        checks++;
        if (ifc.out_valid !== exp_ov) begin
            failures++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc_n, ifc.out_valid, exp_ov);
        end
        checks++;
        if (ifc.in_ready !== exp_ir) begin
            failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc_n, ifc.in_ready, exp_ir);
        end
        checks++;
        if (ifc.scan_busy !== busy_m || ifc.scan_done !== done_due) begin
            failures++; $display("FAIL busy_done cyc=%0d got=%b/%b exp=%b/%b", cyc_n,
                                 ifc.scan_busy, ifc.scan_done, busy_m, done_due);
        end
        if (busy_m && k_in < NPTS) begin
            checks++;
            if (ifc.pt_idx !== 2'(k_in)) begin
                failures++; $display("FAIL pt_idx cyc=%0d got=%0d exp=%0d", cyc_n, ifc.pt_idx, k_in);
            end
        end
        if (exp_ov) begin
            p = q[0];
            checks++;
            if (ifc.out_px !== p.px || ifc.out_py !== p.py || ifc.out_pz !== p.pz ||
                ifc.out_dt !== p.dt || ifc.out_a_x !== p.ax || ifc.out_v_prev !== p.vp) begin
                failures++;
                $display("FAIL point cyc=%0d got px=%h py=%h pz=%h dt=%h ax=%h vp=%h exp px=%h py=%h pz=%h dt=%h ax=%h vp=%h",
                         cyc_n, ifc.out_px, ifc.out_py, ifc.out_pz, ifc.out_dt, ifc.out_a_x, ifc.out_v_prev,
                         p.px, p.py, p.pz, p.dt, p.ax, p.vp);
            end
        end
        idle_m   = !busy_m && !done_due;
        done_nxt = 1'b0;
        if (exp_ov && ordy) begin
            seen_vp.push_back(ifc.out_v_prev);
            seen_ax.push_back(ifc.out_a_x);
            v_last_m = q[0].vp + VSTEP;
            void'(q.pop_front());
            k_out++;
            if (k_out == NPTS) begin
                busy_m = 0; done_nxt = 1'b1;
            end
        end
        if (exp_ir && iv) begin
            p.px = ifc.in_px; p.py = ifc.in_py; p.pz = ifc.in_pz;
            p.dt = exp_dt(k_in); p.ax = ax_m; p.vp = v0_m + VSTEP * k_in;
            q.push_back(p);
            k_in++;
            last_acc_cyc = cyc_n;
        end
        if (imv) ax_m = ax;
        if (st && idle_m) begin
            busy_m = 1; k_in = 0; k_out = 0;
`ifdef SCAN_VEL_CARRY_EN
            v0_m = v_last_m;
`else
            v0_m = '0;
`endif
        end
        if (ifc.scan_done === 1'b1) done_cyc = cyc_n;
        done_due = done_nxt;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic drain_until_idle(input bit rnd);
        int n = 0;
        while ((busy_m || done_due) && n < 200) begin
            drive_cycle(0, rnd ? 1'($urandom) : 1'b0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1,
                        rnd ? ($urandom_range(0, 4) == 0) : 1'b0, $urandom);
            n++;
        end
        checks++;
        if (busy_m || done_due) begin
            failures++; $display("FAIL drain_timeout got=busy exp=idle");
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 0 || ifc.in_ready !== 0 || ifc.scan_busy !== 0 || ifc.scan_done !== 0 ||
            ifc.pt_idx !== 0 || ifc.out_px !== 0 || ifc.out_py !== 0 || ifc.out_pz !== 0 ||
            ifc.out_dt !== 0 || ifc.out_a_x !== 0 || ifc.out_v_prev !== 0) begin
            failures++;
            $display("FAIL reset_values got ov=%b ir=%b busy=%b done=%b idx=%0d px=%h dt=%h ax=%h vp=%h exp all 0",
                     ifc.out_valid, ifc.in_ready, ifc.scan_busy, ifc.scan_done, ifc.pt_idx,
                     ifc.out_px, ifc.out_dt, ifc.out_a_x, ifc.out_v_prev);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        ifc.scan_start = 0; ifc.in_valid = 0; ifc.out_ready = 0; ifc.imu_valid = 0;
        ifc.in_px = '0; ifc.in_py = '0; ifc.in_pz = '0; ifc.imu_ax = '0;
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, 0, '0);
    endtask

    task automatic test_basic_scan();
        drive_cycle(1, 0, 1, 0, '0);
        for (int i = 0; i < NPTS; i++) drive_cycle(0, 1, 1, 0, '0);
        done_cyc = -1;
        drain_until_idle(0);
        checks++;
        if (done_cyc !== last_acc_cyc + 2) begin
            failures++; $display("FAIL done_latency got=%0d exp=%0d", done_cyc - last_acc_cyc, 2);
        end
        drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(1, 0, 1, 0, '0);
        #1;
        checks++;
        if (ifc.pt_idx !== 2'd0 || ifc.scan_busy !== 1'b1) begin
            failures++; $display("FAIL restart_idx got idx=%0d busy=%b exp idx=0 busy=1", ifc.pt_idx, ifc.scan_busy);
        end
        for (int i = 0; i < NPTS; i++) drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
    endtask

    task automatic test_velocity_loop();
        apply_reset();
        seen_vp.delete();
        drive_cycle(1, 0, 1, 0, '0);
        for (int i = 0; i < NPTS; i++) drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
        for (int i = 0; i < NPTS; i++) begin
            checks++;
            if (seen_vp.size() <= i || seen_vp[i] !== VSTEP * i) begin
                failures++;
                $display("FAIL v_prev[%0d] got=%h exp=%h", i, (seen_vp.size() > i) ? seen_vp[i] : 32'hx, VSTEP * i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap_px, snap_dt;
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        #1;
        snap_px = ifc.out_px; snap_dt = ifc.out_dt;
        #1;
        for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0, 0, '0);
        #1;
        checks++;
        if (ifc.out_px !== snap_px || ifc.out_dt !== snap_dt || ifc.in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_hold got px=%h dt=%h ir=%b exp px=%h dt=%h ir=0",
                                 ifc.out_px, ifc.out_dt, ifc.in_ready, snap_px, snap_dt);
        end
        #1;
        drain_until_idle(1);
    endtask

    task automatic test_imu_timing();
        seen_ax.delete();
        drive_cycle(0, 0, 1, 1, 32'h1234);
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(0, 1, 1, 1, 32'h8000);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
        checks++;
        if (seen_ax.size() < 3 || seen_ax[1] !== 32'h1234 || seen_ax[2] !== 32'h8000) begin
            failures++; $display("FAIL imu_ax got p1=%h p2=%h exp p1=00001234 p2=00008000",
                                 (seen_ax.size() > 1) ? seen_ax[1] : 32'hx, (seen_ax.size() > 2) ? seen_ax[2] : 32'hx);
        end
    endtask

    task automatic test_control_edges();
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(1, 1, 1, 0, '0);
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(0, 1, 0, 0, '0);
        apply_reset();
        for (int i = 0; i < 5; i++) drive_cycle(0, 1, 1, 0, '0);
    endtask

    task automatic test_vel_carry();
        logic [31:0] exp_v;
        apply_reset();
        drive_cycle(1, 0, 1, 0, '0);
        for (int i = 0; i < NPTS; i++) drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
        seen_vp.delete();
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, '0);
        drive_cycle(0, 0, 1, 0, '0);
`ifdef SCAN_VEL_CARRY_EN
        exp_v = VSTEP * NPTS;
`else
        exp_v = '0;
`endif
        checks++;
        if (seen_vp.size() < 1 || seen_vp[0] !== exp_v) begin
            failures++; $display("FAIL vel_carry got=%h exp=%h", (seen_vp.size() > 0) ? seen_vp[0] : 32'hx, exp_v);
        end
        for (int i = 1; i < NPTS; i++) drive_cycle(0, 1, 1, 0, '0);
        drain_until_idle(0);
    endtask

    task automatic test_random_scans();
        for (int s = 0; s < 12; s++) begin
            drive_cycle(1, 0, 1'($urandom), 1'($urandom), $urandom);
            drain_until_idle(1);
            drive_cycle(0, 0, 1, 0, '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cyc_n = 0; last_acc_cyc = 0; done_cyc = -1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_scan();
        test_velocity_loop();
        test_backpressure();
        test_imu_timing();
        test_control_edges();
        test_vel_carry();
        test_random_scans();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/scan_point_feeder.md
# scan_point_feeder

Sequencer that feeds one LiDAR scan, point by point, into the motion-correction datapath, which consumes `px/py/pz`, `dt`, `a_x`, `v_prev` and returns `v_next`. It accepts raw points through a valid/ready stream. It stamps each point with its rolling-shutter time offset from scan start and attaches the latest IMU acceleration. It closes the velocity loop by registering the corrector's `v_next` back into `v_prev` for the next point. It sits between the point-capture FIFO and the corrector, and signals scan completion upstream.

## Interface
- `WP`, 32, word width; all data Q16.16 signed
- `NPTS`, 1024, points per scan (≥2)
- `DT_STEP`, 13, per-point time increment, Q16.16 seconds (≈0.2 s / 1024)

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `scan_start`  in  1  one-cycle pulse; starts a scan when idle
- `in_valid`  in  1  raw point valid
- `in_ready`  out  1  feeder can take a point
- `in_px`, `in_py`, `in_pz`  in  WP each  raw point
- `imu_valid`  in  1  new acceleration sample
- `imu_ax`  in  WP  acceleration, Q16.16
- `out_valid`  out  1  corrector input valid
- `out_ready`  in  1  corrector side accepts
- `out_px`, `out_py`, `out_pz`  out  WP each  point to corrector
- `out_dt`  out  WP  time offset of this point
- `out_a_x`  out  WP  acceleration for this point
- `out_v_prev`  out  WP  velocity entering this point
- `v_next_in`  in  WP  corrector `v_next` for the point currently on `out_*`; combinational from the `out_*` regs
- `scan_busy`  out  1  high in RUN and DRAIN
- `scan_done`  out  1  one-cycle pulse at end of scan
- `pt_idx`  out  clog2(NPTS)  index of next point to accept

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `scan_start`.
  - Clears `pt_idx` and `dt_acc` to 0.
  - Clears `v_reg` to 0 (see Configuration).
- RUN:
  - `in_ready = !out_valid | out_ready`, so there is a single output register with pass-through on back-pressure.
  - An accept (`in_valid & in_ready`) loads `out_p*` ← `in_p*`, `out_dt` ← `dt_acc`, `out_a_x` ← `ax_reg`, and sets `out_valid`.
  - The same accept does `dt_acc += DT_STEP`, saturating at 0x7FFF_FFFF, and `pt_idx += 1`.
- `out_v_prev` is always `v_reg`.
- On an output handshake (`out_valid & out_ready`): `v_reg` ← `v_next_in`, and `out_valid` clears unless a new accept occurs in the same cycle.
- When the accept with `pt_idx == NPTS-1` occurs, the FSM goes to DRAIN and `in_ready` drops to 0.
- DRAIN → DONE on the output handshake of the last point. DONE lasts one cycle with `scan_done = 1`, then → IDLE.
- `ax_reg` ← `imu_ax` on every `imu_valid`, in any state. A point accepted in the same cycle gets the old `ax_reg`.
- `scan_start` outside IDLE is ignored.
- `out_*` data registers hold their value while `out_valid = 0`.

## Timing
- Reset values:
  - state IDLE
  - all `out_*` data, `pt_idx`, `dt_acc`, `v_reg`, `ax_reg` = 0
  - `out_valid`, `in_ready`, `scan_busy`, `scan_done` = 0
- Latency is 1 cycle from input accept to `out_valid`.
- Full throughput is one point per cycle while `out_ready = 1`.
- Back-to-back points: point k+1 sees the `v_reg` written by point k's handshake, since that handshake precedes or coincides with point k+1's load. `out_v_prev` of point k+1 is valid from the cycle after point k's handshake.
- `in_ready` is 0 in IDLE, DRAIN and DONE.
- `scan_busy` is high in RUN and DRAIN.
- `out_valid` must not drop without a handshake.
- Asynchronous reset mid-scan discards everything; there is no `scan_done` pulse.

## Configuration
- `SCAN_VEL_CARRY_EN` defined: `v_reg` is not cleared on `scan_start`, so velocity carries across consecutive scans.
- `SCAN_VEL_CARRY_EN` undefined: `v_reg` is cleared to 0 on every `scan_start`.

## Test plan
- **Basic scan.** NPTS=4, `scan_start`, 4 points, `out_ready=1`.
  - `out_dt` = 0, 13, 26, 39.
  - `scan_done` pulses exactly 2 cycles after the last accept.
  - `pt_idx` returns to 0 at the next `scan_start`.
- **Velocity loop.** Bench models `v_next_in = out_v_prev + 0x10000`.
  - 4 points give `out_v_prev` = 0, 0x10000, 0x20000, 0x30000.
- **Back-pressure.** Hold `out_ready=0` for 5 cycles after the first point.
  - `in_ready=0` and the outputs are stable during the stall.
  - On release, there is no point loss or duplication, and the order is preserved.
- **IMU timing.** `imu_valid` with ax=0x8000 in the same cycle as the accept of point 1.
  - Point 1 gets the old ax.
  - Point 2 gets 0x8000.
- **Control edges.**
  - `scan_start` during RUN is ignored.
  - `rst_n` low mid-scan forces all outputs to their reset values, with no `scan_done`.
- **Velocity carry.** Second scan with `SCAN_VEL_CARRY_EN` defined: first `out_v_prev` equals the last `v_next_in` of scan 1. Undefined: first `out_v_prev` = 0.
